// File: rtl/accel_dispatch_pkg.sv
// Shared types and constants for the accelerator dispatch controller.
package accel_dispatch_pkg;

    localparam int DATA_W_DEF = 16;

    localparam logic OP_FFT    = 1'b0;
    localparam logic OP_CRYPTO = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_WB,
        S_ERR
    } state_e;

endpackage

// File: rtl/accel_timeout_ctr.sv
// Saturating wait-cycle counter; expired flags the last allowed WAIT cycle.
module accel_timeout_ctr
    import accel_dispatch_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturate at LAST so a long wait can never wrap back below the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/accel_dispatch.sv
// Issues one accelerator instruction, waits for its done pulse (or times out)
// and returns the result to writeback. Every output is a flop.
module accel_dispatch
    import accel_dispatch_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_op,
    input  logic [2:0]        issue_rd,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    output logic [DATA_W-1:0] acc_op_a,
    output logic [DATA_W-1:0] acc_op_b,
    output logic              fft_start,
    input  logic              fft_done,
    input  logic [DATA_W-1:0] fft_result,
    output logic              crypto_start,
    input  logic              crypto_done,
    input  logic [DATA_W-1:0] crypto_result,
    output logic              fft_busy,
    output logic              crypto_busy,
    output logic              exception,
    input  logic              exc_clear,
    output logic              wb_valid,
    output logic [2:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    state_e            state_q, state_d;
    logic              op_q, op_d;
    logic [2:0]        rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              fft_start_q, fft_start_d;
    logic              crypto_start_q, crypto_start_d;
    logic              fft_busy_q, fft_busy_d;
    logic              crypto_busy_q, crypto_busy_d;
    logic              exception_q, exception_d;
    logic              wb_valid_q, wb_valid_d;

    logic              ctr_clear;
    logic              ctr_enable;
    logic              timeout_expired;
    logic              sel_done;
    logic [DATA_W-1:0] sel_result;
    logic              in_flight;

    assign ctr_clear  = (state_q == S_START);
    assign ctr_enable = (state_q == S_WAIT);

    accel_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clear),
        .enable  (ctr_enable),
        .expired (timeout_expired)
    );

    // Only the accelerator we launched may complete the instruction.
    assign sel_done   = (op_q == OP_FFT) ? fft_done   : crypto_done;
    assign sel_result = (op_q == OP_FFT) ? fft_result : crypto_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            op_q           <= OP_FFT;
            rd_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            fft_start_q    <= 1'b0;
            crypto_start_q <= 1'b0;
            fft_busy_q     <= 1'b0;
            crypto_busy_q  <= 1'b0;
            exception_q    <= 1'b0;
            wb_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            rd_q           <= rd_d;
            a_q            <= a_d;
            b_q            <= b_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            fft_start_q    <= fft_start_d;
            crypto_start_q <= crypto_start_d;
            fft_busy_q     <= fft_busy_d;
            crypto_busy_q  <= crypto_busy_d;
            exception_q    <= exception_d;
            wb_valid_q     <= wb_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        a_d       = a_q;
        b_d       = b_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    state_d = S_START;
                    op_d    = issue_op;
                    rd_d    = issue_rd;
                    a_d     = issue_a;
                    b_d     = issue_b;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                // A done arriving on the final cycle still beats the timeout.
                if (sel_done) begin
                    state_d   = S_WB;
                    wb_data_d = sel_result;
                    wb_rd_d   = rd_q;
                end else if (timeout_expired) begin
                    state_d = S_ERR;
                end
            end
            S_WB: state_d = S_IDLE;
            S_ERR: begin
                if (exc_clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        in_flight      = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_WB);
        fft_start_d    = (state_d == S_START) && (op_d == OP_FFT);
        crypto_start_d = (state_d == S_START) && (op_d == OP_CRYPTO);
        fft_busy_d     = in_flight && (op_d == OP_FFT);
        crypto_busy_d  = in_flight && (op_d == OP_CRYPTO);
        exception_d    = (state_d == S_ERR);
        wb_valid_d     = (state_d == S_WB);
    end

    assign acc_op_a     = a_q;
    assign acc_op_b     = b_q;
    assign fft_start    = fft_start_q;
    assign crypto_start = crypto_start_q;
    assign fft_busy     = fft_busy_q;
    assign crypto_busy  = crypto_busy_q;
    assign exception    = exception_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_accel_dispatch.sv
// Self-checking bench for accel_dispatch: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level model.
module tb_accel_dispatch;

    localparam int DW  = 16;
    localparam int TMO = 8;

    logic          clk;
    logic          rst;
    logic          issue_valid;
    logic          issue_op;
    logic [2:0]    issue_rd;
    logic [DW-1:0] issue_a;
    logic [DW-1:0] issue_b;
    logic [DW-1:0] acc_op_a;
    logic [DW-1:0] acc_op_b;
    logic          fft_start;
    logic          fft_done;
    logic [DW-1:0] fft_result;
    logic          crypto_start;
    logic          crypto_done;
    logic [DW-1:0] crypto_result;
    logic          fft_busy;
    logic          crypto_busy;
    logic          exception;
    logic          exc_clear;
    logic          wb_valid;
    logic [2:0]    wb_rd;
    logic [DW-1:0] wb_data;

    int            checks = 0;
    int            errors = 0;
    int            cur_k  = 0;
    int            txn_n  = 0;
    logic [2:0]    mdl_wb_rd   = '0;
    logic [DW-1:0] mdl_wb_data = '0;
    logic [DW-1:0] mdl_a       = '0;
    logic [DW-1:0] mdl_b       = '0;

    accel_dispatch #(
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_op      (issue_op),
        .issue_rd      (issue_rd),
        .issue_a       (issue_a),
        .issue_b       (issue_b),
        .acc_op_a      (acc_op_a),
        .acc_op_b      (acc_op_b),
        .fft_start     (fft_start),
        .fft_done      (fft_done),
        .fft_result    (fft_result),
        .crypto_start  (crypto_start),
        .crypto_done   (crypto_done),
        .crypto_result (crypto_result),
        .fft_busy      (fft_busy),
        .crypto_busy   (crypto_busy),
        .exception     (exception),
        .exc_clear     (exc_clear),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
        end
    endtask

    task automatic expect_outputs(input logic fs, input logic cs, input logic fb,
                                  input logic cb, input logic wv, input logic ex);
        chk("fft_start",    32'(fft_start),    32'(fs));
        chk("crypto_start", 32'(crypto_start), 32'(cs));
        chk("fft_busy",     32'(fft_busy),     32'(fb));
        chk("crypto_busy",  32'(crypto_busy),  32'(cb));
        chk("wb_valid",     32'(wb_valid),     32'(wv));
        chk("exception",    32'(exception),    32'(ex));
        chk("wb_rd",        32'(wb_rd),        32'(mdl_wb_rd));
        chk("wb_data",      32'(wb_data),      32'(mdl_wb_data));
        chk("acc_op_a",     32'(acc_op_a),     32'(mdl_a));
        chk("acc_op_b",     32'(acc_op_b),     32'(mdl_b));
    endtask

    // Called at a negedge with the DUT idle. d = cycles from the start pulse to
    // the selected done; d outside 1..TMO means the op must time out.
    task automatic run_txn(input logic op, input logic [2:0] rd, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input int d, input logic [DW-1:0] res,
                           input bit stray, input bit ign, input bit sp);
        bit   ok_done;
        int   end_k;
        int   last_k;
        int   h;
        logic e_start, e_busy, e_wb, e_exc, sel, oth;
        ok_done = (d >= 1) && (d <= TMO);
        end_k   = ok_done ? d + 1 : TMO + 1;
        last_k  = ok_done ? end_k + 1 : end_k;
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rd    = rd;
        issue_a     = a;
        issue_b     = b;
        mdl_a       = a;
        mdl_b       = b;
        for (int k = 0; k <= last_k; k++) begin
            @(negedge clk);
            cur_k = k;
            if (ok_done && k == end_k) begin
                mdl_wb_rd   = rd;
                mdl_wb_data = res;
            end
            e_start = (k == 0);
            e_busy  = ok_done ? (k <= end_k) : (k < end_k);
            e_wb    = ok_done && (k == end_k);
            e_exc   = !ok_done && (k == end_k);
            expect_outputs(e_start && !op, e_start && op, e_busy && !op, e_busy && op, e_wb, e_exc);

            issue_valid = ign && (k < end_k) && ($urandom_range(0, 1) == 1);
            if (issue_valid) begin
                issue_rd = rd ^ 3'($urandom_range(1, 7));
                issue_a  = DW'($urandom);
                issue_b  = DW'($urandom);
                issue_op = 1'($urandom);
            end
            sel = (k == d) || (sp && k == 0);
            oth = stray && ($urandom_range(0, 1) == 1);
            fft_done      = op ? oth : sel;
            crypto_done   = op ? sel : oth;
            fft_result    = (!op && k == d) ? res : DW'($urandom);
            crypto_result = ( op && k == d) ? res : DW'($urandom);
        end
        if (!ok_done) begin
            h = $urandom_range(0, 3);
            for (int j = 0; j < h; j++) begin
                @(negedge clk);
                cur_k = end_k + 1 + j;
                expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            exc_clear   = 1'b1;
            fft_done    = 1'b0;
            crypto_done = 1'b0;
            @(negedge clk);
            cur_k = end_k + 1 + h;
            expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exc_clear = 1'b0;
        end
        txn_n++;
        $display("txn %0d op=%0d rd=%0d d=%0d stray=%0d ign=%0d outcome=%s",
                 txn_n, op, rd, d, stray, ign, ok_done ? "writeback" : "timeout");
    endtask

    initial begin
        rst           = 1'b0;
        issue_valid   = 1'b0;
        issue_op      = 1'b0;
        issue_rd      = '0;
        issue_a       = '0;
        issue_b       = '0;
        fft_done      = 1'b0;
        fft_result    = '0;
        crypto_done   = 1'b0;
        crypto_result = '0;
        exc_clear     = 1'b0;

        // Reset asserted between clock edges must clear outputs at once.
        #2 rst = 1'b1;
        #1 cur_k = -1;
        expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_txn(1'b0, 3'd3, 16'h1234, 16'h0002, 5, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 3'd6, 16'hA5A5, 16'h0F0F, 4, 16'hC0DE, 1'b1, 1'b0, 1'b0);
        run_txn(1'b0, 3'd1, 16'h1111, 16'h2222, TMO + 5, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 3'd2, 16'h3333, 16'h4444, TMO, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 3'd5, 16'h7777, 16'h8888, 3, 16'h1357, 1'b1, 1'b1, 1'b1);
        run_txn(1'b1, 3'd7, 16'h9999, 16'hAAAA, 1, 16'h2468, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_txn(1'($urandom), 3'($urandom), DW'($urandom), DW'($urandom),
                    $urandom_range(1, TMO + 2), DW'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of a crypto op: nothing may follow it.
        issue_valid = 1'b1;
        issue_op    = 1'b1;
        issue_rd    = 3'd4;
        issue_a     = 16'hDEAD;
        issue_b     = 16'hF00D;
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        crypto_done   = 1'b1;
        crypto_result = 16'h6666;
        #1 mdl_wb_rd = '0;
        mdl_wb_data = '0;
        mdl_a       = '0;
        mdl_b       = '0;
        cur_k       = -2;
        expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < TMO + 3; k++) begin
            @(negedge clk);
            cur_k = k;
            expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            crypto_done = 1'($urandom);
            fft_done    = 1'($urandom);
        end
        fft_done    = 1'b0;
        crypto_done = 1'b0;
        run_txn(1'b0, 3'd2, 16'h0101, 16'h0202, 2, 16'h4242, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
